// File: rtl/regfile_mp_if.sv
// Bus between decode/writeback (master) and the multi-port register file (slave).
// Carries the write port, NUM_RD read ports and the busy-scoreboard signals.
interface regfile_mp_if #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2
);
    localparam int AW = $clog2(NUM_REGS);

    logic                   wr_en;
    logic [AW-1:0]          wr_addr;
    logic [XLEN-1:0]        wr_data;
    logic [NUM_RD-1:0]      rd_en;
    logic [NUM_RD*AW-1:0]   rd_addr;
    logic [NUM_RD*XLEN-1:0] rd_data;
    logic [NUM_RD-1:0]      rd_busy;
    logic                   sb_set;
    logic [AW-1:0]          sb_addr;
    logic [NUM_REGS-1:0]    busy_vec;

    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr, sb_set, sb_addr,
        input  rd_data, rd_busy, busy_vec
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr, sb_set, sb_addr,
        output rd_data, rd_busy, busy_vec
    );
endinterface

// File: rtl/regfile_mp.sv
// Register file: NUM_RD registered read ports, one write port, x0 hardwired to zero, busy scoreboard.
// Define REGFILE_BYPASS_EN for write-first reads; the default build is read-first.
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2
) (
    input logic         clk,
    input logic         reset,
    regfile_mp_if.slave bus
);
    localparam int AW = $clog2(NUM_REGS);

    logic [XLEN-1:0]     mem [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;
    logic                wr_ok;

    assign wr_ok = bus.wr_en && (bus.wr_addr != '0);

    // A set and a clear on the same register: the new producer wins.
    always_comb begin
        busy_nxt = busy;
        if (wr_ok) busy_nxt[bus.wr_addr] = 1'b0;
        if (bus.sb_set && (bus.sb_addr != '0)) busy_nxt[bus.sb_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy <= '0;
            for (int r = 0; r < NUM_REGS; r++) mem[r] <= '0;
        end else begin
            busy <= busy_nxt;
            if (wr_ok) mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    assign bus.busy_vec = busy;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0]   ra;
        logic            hit;
        logic [XLEN-1:0] data;
        logic            bsy;
        logic [XLEN-1:0] data_q;
        logic            bsy_q;

        assign ra = bus.rd_addr[i*AW +: AW];
`ifdef REGFILE_BYPASS_EN
        assign hit = wr_ok && (bus.wr_addr == ra);
`else
        assign hit = 1'b0;
`endif
        // A bypassed read sees the post-update scoreboard, otherwise the pre-update one.
        assign data = hit ? bus.wr_data : ((ra == '0) ? '0 : mem[ra]);
        assign bsy  = hit ? busy_nxt[ra] : busy[ra];

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                data_q <= '0;
                bsy_q  <= 1'b0;
            end else if (bus.rd_en[i]) begin
                data_q <= data;
                bsy_q  <= bsy;
            end
        end

        assign bus.rd_data[i*XLEN +: XLEN] = data_q;
        assign bus.rd_busy[i]              = bsy_q;
    end
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed table, reset pulse, random run against an array model,
// plus a wide 4-port instance for packed-port checks.
module tb_regfile_mp;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    regfile_mp_if #(.XLEN(32), .NUM_REGS(32), .NUM_RD(2)) ifa ();
    regfile_mp_if #(.XLEN(64), .NUM_REGS(16), .NUM_RD(4)) ifb ();

    regfile_mp #(.XLEN(32), .NUM_REGS(32), .NUM_RD(2)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
    regfile_mp #(.XLEN(64), .NUM_REGS(16), .NUM_RD(4)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] m_mem [32];
    bit          m_busy [32];
    logic [31:0] exp_rd [2];
    logic        exp_rb [2];

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [1:0]  re;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic        ss;
        logic [4:0]  sa;
        logic [31:0] e_rd0;
        logic [31:0] e_rd1;
        logic [1:0]  e_rb;
        logic [31:0] e_bv;
    } vec_t;

    vec_t tbl [16];

    function automatic vec_t v(logic we, logic [4:0] wa, logic [31:0] wd, logic [1:0] re,
                               logic [4:0] ra0, logic [4:0] ra1, logic ss, logic [4:0] sa,
                               logic [31:0] e0, logic [31:0] e1, logic [1:0] erb, logic [31:0] ebv);
        vec_t r;
        r.we = we; r.wa = wa; r.wd = wd; r.re = re; r.ra0 = ra0; r.ra1 = ra1;
        r.ss = ss; r.sa = sa; r.e_rd0 = e0; r.e_rd1 = e1; r.e_rb = erb; r.e_bv = ebv;
        return r;
    endfunction

    function automatic logic [63:0] valb(int i);
        return 64'h0123_4567_0000_0000 + 64'(i) * 64'h0000_0001_0000_0101;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin
            m_mem[r] = '0;
            m_busy[r] = 1'b0;
        end
        for (int p = 0; p < 2; p++) begin
            exp_rd[p] = '0;
            exp_rb[p] = 1'b0;
        end
    endtask

    task automatic drive_a(logic we, logic [4:0] wa, logic [31:0] wd, logic [1:0] re,
                           logic [4:0] ra0, logic [4:0] ra1, logic ss, logic [4:0] sa);
        ifa.wr_en = we; ifa.wr_addr = wa; ifa.wr_data = wd;
        ifa.rd_en = re; ifa.rd_addr = {ra1, ra0};
        ifa.sb_set = ss; ifa.sb_addr = sa;
    endtask

    // One clock on instance A: snapshot inputs, advance, update model, compare.
    task automatic tick_a();
        logic        we, ss;
        logic [4:0]  wa, sa;
        logic [31:0] wd;
        logic [1:0]  re;
        logic [4:0]  ra [2];
        logic [31:0] bv;
        we = ifa.wr_en; wa = ifa.wr_addr; wd = ifa.wr_data; re = ifa.rd_en;
        ra[0] = ifa.rd_addr[4:0]; ra[1] = ifa.rd_addr[9:5];
        ss = ifa.sb_set; sa = ifa.sb_addr;
        @(posedge clk); #1;
        for (int p = 0; p < 2; p++) begin
            if (re[p]) begin
                if (BYP && we && wa == ra[p] && ra[p] != 0) begin
                    exp_rd[p] = wd;
                    exp_rb[p] = ss && (sa == ra[p]);
                end else begin
                    exp_rd[p] = (ra[p] == 0) ? 32'h0 : m_mem[ra[p]];
                    exp_rb[p] = m_busy[ra[p]];
                end
            end
        end
        if (we && wa != 0) begin
            m_mem[wa] = wd;
            m_busy[wa] = 1'b0;
        end
        if (ss && sa != 0) m_busy[sa] = 1'b1;
        bv = '0;
        for (int r = 0; r < 32; r++) bv[r] = m_busy[r];
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("a_rd_data%0d", p), 64'(ifa.rd_data[p*32 +: 32]), 64'(exp_rd[p]));
            chk($sformatf("a_rd_busy%0d", p), 64'(ifa.rd_busy[p]), 64'(exp_rb[p]));
        end
        chk("a_busy_vec", 64'(ifa.busy_vec), 64'(bv));
    endtask

    initial begin
        tbl[0]  = v(0, 0, 32'h0,        2'b01, 0, 0, 0, 0, 32'h0, 32'h0, 2'b00, 32'h0);
        tbl[1]  = v(0, 0, 32'h0,        2'b01, 5, 0, 0, 0, 32'h0, 32'h0, 2'b00, 32'h0);
        tbl[2]  = v(0, 0, 32'h0,        2'b01, 31, 0, 0, 0, 32'h0, 32'h0, 2'b00, 32'h0);
        tbl[3]  = v(1, 7, 32'hDEADBEEF, 2'b00, 0, 0, 0, 0, 32'h0, 32'h0, 2'b00, 32'h0);
        tbl[4]  = v(0, 0, 32'h0,        2'b11, 7, 7, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 32'h0);
        tbl[5]  = v(1, 0, 32'h1234,     2'b00, 0, 0, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 32'h0);
        tbl[6]  = v(0, 0, 32'h0,        2'b11, 0, 0, 0, 0, 32'h0, 32'h0, 2'b00, 32'h0);
        tbl[7]  = v(1, 9, 32'h11,       2'b00, 0, 0, 0, 0, 32'h0, 32'h0, 2'b00, 32'h0);
        tbl[8]  = v(1, 9, 32'hA5A5A5A5, 2'b01, 9, 0, 0, 0,
                    BYP ? 32'hA5A5A5A5 : 32'h11, 32'h0, 2'b00, 32'h0);
        tbl[9]  = v(0, 0, 32'h0,        2'b11, 9, 9, 0, 0, 32'hA5A5A5A5, 32'hA5A5A5A5, 2'b00, 32'h0);
        tbl[10] = v(0, 0, 32'h0,        2'b00, 0, 0, 1, 3, 32'hA5A5A5A5, 32'hA5A5A5A5, 2'b00, 32'h8);
        tbl[11] = v(1, 3, 32'h33,       2'b00, 0, 0, 0, 0, 32'hA5A5A5A5, 32'hA5A5A5A5, 2'b00, 32'h0);
        tbl[12] = v(1, 3, 32'h44,       2'b00, 0, 0, 1, 3, 32'hA5A5A5A5, 32'hA5A5A5A5, 2'b00, 32'h8);
        tbl[13] = v(0, 0, 32'h0,        2'b10, 0, 3, 0, 0, 32'hA5A5A5A5, 32'h44, 2'b10, 32'h8);
        tbl[14] = v(0, 0, 32'h0,        2'b00, 0, 0, 1, 4, 32'hA5A5A5A5, 32'h44, 2'b10, 32'h18);
        tbl[15] = v(0, 0, 32'h0,        2'b00, 0, 0, 1, 6, 32'hA5A5A5A5, 32'h44, 2'b10, 32'h58);

        drive_a(0, 0, 0, 2'b00, 0, 0, 0, 0);
        ifb.wr_en = 1'b0; ifb.wr_addr = '0; ifb.wr_data = '0;
        ifb.rd_en = '0; ifb.rd_addr = '0; ifb.sb_set = 1'b0; ifb.sb_addr = '0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy_vec", 64'(ifa.busy_vec), 64'h0);
        chk("reset_rd_data", 64'(ifa.rd_data), 64'h0);
        chk("reset_rd_busy", 64'(ifa.rd_busy), 64'h0);
        reset = 1'b1;

        for (int k = 0; k < 16; k++) begin
            drive_a(tbl[k].we, tbl[k].wa, tbl[k].wd, tbl[k].re,
                    tbl[k].ra0, tbl[k].ra1, tbl[k].ss, tbl[k].sa);
            tick_a();
            chk($sformatf("tbl%0d_rd0", k), 64'(ifa.rd_data[31:0]), 64'(tbl[k].e_rd0));
            chk($sformatf("tbl%0d_rd1", k), 64'(ifa.rd_data[63:32]), 64'(tbl[k].e_rd1));
            chk($sformatf("tbl%0d_rb", k), 64'(ifa.rd_busy), 64'(tbl[k].e_rb));
            chk($sformatf("tbl%0d_bv", k), 64'(ifa.busy_vec), 64'(tbl[k].e_bv));
        end

        // Reset pulse between edges with x4/x6 busy: everything clears without a clock.
        drive_a(0, 0, 0, 2'b00, 0, 0, 0, 0);
        reset = 1'b0;
        #1;
        chk("pulse_busy_vec", 64'(ifa.busy_vec), 64'h0);
        chk("pulse_rd_data", 64'(ifa.rd_data), 64'h0);
        chk("pulse_rd_busy", 64'(ifa.rd_busy), 64'h0);
        model_reset();
        #1;
        reset = 1'b1;
        drive_a(0, 0, 0, 2'b01, 4, 0, 0, 0);
        tick_a();
        chk("post_reset_x4", 64'(ifa.rd_data[31:0]), 64'h0);

        for (int n = 0; n < 400; n++) begin
            logic [4:0] a [4];
            for (int j = 0; j < 4; j++)
                a[j] = ($urandom % 2 == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            drive_a(1'($urandom % 2), a[0], $urandom, 2'($urandom_range(0, 3)),
                    a[1], a[2], ($urandom % 3) == 0, a[3]);
            tick_a();
        end
        drive_a(0, 0, 0, 2'b00, 0, 0, 0, 0);

        for (int i = 1; i < 16; i++) begin
            ifb.wr_en = 1'b1; ifb.wr_addr = 4'(i); ifb.wr_data = valb(i);
            @(posedge clk); #1;
        end
        ifb.wr_en = 1'b0;
        ifb.rd_en = 4'hF;
        ifb.rd_addr = {4'd8, 4'd8, 4'd15, 4'd1};
        @(posedge clk); #1;
        chk("b_p0_x1",  ifb.rd_data[0*64 +: 64], valb(1));
        chk("b_p1_x15", ifb.rd_data[1*64 +: 64], valb(15));
        chk("b_p2_x8",  ifb.rd_data[2*64 +: 64], valb(8));
        chk("b_p3_x8",  ifb.rd_data[3*64 +: 64], valb(8));
        ifb.rd_en = 4'b0101;
        ifb.rd_addr = {4'd0, 4'd3, 4'd0, 4'd2};
        @(posedge clk); #1;
        chk("b_p0_x2",   ifb.rd_data[0*64 +: 64], valb(2));
        chk("b_p1_hold", ifb.rd_data[1*64 +: 64], valb(15));
        chk("b_p2_x3",   ifb.rd_data[2*64 +: 64], valb(3));
        chk("b_p3_hold", ifb.rd_data[3*64 +: 64], valb(8));
        chk("b_rd_busy", 64'(ifb.rd_busy), 64'h0);
        chk("b_busy_vec", 64'(ifb.busy_vec), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the core's single-write/dual-read register file. Single clock edge only; the dual-edge scheme is gone.
- Provides NUM_RD registered read ports and one write port, with register 0 hardwired to zero.
- Adds a per-register busy scoreboard, so decode can stall on pending writebacks.
- Sits between decode (read/issue) and writeback (write/clear).

Parameters:
- XLEN, 32, data width in bits.
- NUM_REGS, 32, number of architectural registers; power of two, at least 2.
- NUM_RD, 2, number of read ports, 1..4.
- AW, $clog2(NUM_REGS), address width; derived, not overridable.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  write strobe from writeback.
- wr_addr  in  AW  write register index.
- wr_data  in  XLEN  write data.
- rd_en  in  NUM_RD  per-port read strobe.
- rd_addr  in  NUM_RD*AW  packed read indices; port i occupies bits [i*AW +: AW].
- rd_data  out  NUM_RD*XLEN  packed registered read data.
- rd_busy  out  NUM_RD  registered busy flag of the register read on each port.
- sb_set  in  1  issue strobe; marks sb_addr as pending.
- sb_addr  in  AW  destination register being issued.
- busy_vec  out  NUM_REGS  live (combinational) scoreboard bits.

Behaviour:
- Reset (reset=0, asynchronous):
  - all registers cleared to 0.
  - rd_data = 0, rd_busy = 0, busy_vec = 0.
  - state holds while reset is low.
  - The first rising edge after deassertion is a normal cycle.
- Write: on the rising edge with wr_en=1 and wr_addr!=0, mem[wr_addr] <= wr_data. Writes to address 0 are discarded.
- Read: on the rising edge with rd_en[i]=1, the port registers its result.
  - rd_data[i] <= mem[rd_addr[i]] (0 if the address is 0).
  - rd_busy[i] <= busy state of rd_addr[i].
  - Latency is 1 cycle: data appears the cycle after the strobe.
  - With rd_en[i]=0, rd_data[i] and rd_busy[i] hold their previous values.
- Read and write to the same address in the same cycle: behaviour is set by the optional feature below.
- Ports are independent. Any number of ports may read the same address in the same cycle; all return identical data.
- Scoreboard:
  - sb_set=1 and sb_addr!=0 sets busy[sb_addr].
  - wr_en=1 and wr_addr!=0 clears busy[wr_addr].
  - Set and clear of the same address in the same cycle: set wins. The new producer supersedes the retiring one.
  - Set and clear of different addresses: both take effect.
  - busy[0] is constant 0. sb_set to address 0 is ignored.
  - Setting an already-busy register leaves it busy; there is no counting.
- rd_busy uses the pre-update scoreboard value of the read cycle, except where the bypass (optional feature) applies.
- Reset asserted mid-operation: pending writes are lost and all busy bits clear immediately; no partial state survives.
- Address inputs are at most NUM_REGS-1 by construction; out-of-range behaviour is unspecified.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined (write-first): a read with rd_addr[i]==wr_addr!=0 and wr_en=1 in the same cycle returns wr_data.
  - rd_busy[i] then reflects the post-update scoreboard: 0, unless sb_set targets the same address that cycle.
- Undefined (read-first): the read returns the old mem contents and the pre-update busy bit. The pipeline must insert one stall.

Test Plan:
- Reset, then read addresses 0, 5 and 31 on port 0 -> rd_data=0 and rd_busy=0 on each following cycle.
- Write 0xDEADBEEF to x7, then read x7 on ports 0 and 1 next cycle -> both return 0xDEADBEEF after 1 cycle. Write 0x1234 to x0, then read x0 -> 0.
- Read x9 and write 0xA5A5A5A5 to x9 in the same cycle (x9 held 0x11) -> 0xA5A5A5A5 with REGFILE_BYPASS_EN defined, 0x11 without it; either way, a read the following cycle returns 0xA5A5A5A5.
- sb_set x3 -> busy_vec[3]=1. Write x3 -> busy_vec[3]=0. sb_set x3 and write x3 in the same cycle -> busy_vec[3]=1 afterwards.
- Busy x4 and x6, pulse reset low between edges -> busy_vec=0 and rd_data=0 immediately; a read of x4 after release returns 0.
- NUM_RD=4, XLEN=64, NUM_REGS=16: write distinct values to x1..x15, then issue four simultaneous reads of x1, x15, x8, x8 -> correct packed 64-bit values; ports with rd_en=0 hold their prior data.
